// File: rtl/pwm_capture_if.sv
// Bundles the control, pin and result signals of pwm_capture.
// master drives enable/din/ack; slave is the capture block.
interface pwm_capture_if #(
  parameter int COUNT_WIDTH = 16
);
  logic                   enable;
  logic                   din;
  logic                   ack;
  logic [COUNT_WIDTH-1:0] on_ticks;
  logic [COUNT_WIDTH-1:0] off_ticks;
  logic                   valid;
  logic                   overflow;
  logic                   level;

  modport master (
    output enable, din, ack,
    input  on_ticks, off_ticks, valid, overflow, level
  );

  modport slave (
    input  enable, din, ack,
    output on_ticks, off_ticks, valid, overflow, level
  );
endinterface

// File: rtl/pwm_capture.sv
// Measures high and low phase lengths of an asynchronous pin in clock ticks,
// reporting each complete period with a one-cycle valid and a sticky overflow.
module pwm_capture #(
  parameter int COUNT_WIDTH = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic         clock,
  input logic         reset,
  pwm_capture_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    MEAS_HIGH,
    MEAS_LOW
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s, s_d, rise, fall;

  state_t                 state, state_n;
  logic [COUNT_WIDTH-1:0] cnt, cnt_n, cnt_inc;
  logic [COUNT_WIDTH-1:0] hi_latch, hi_n;
  logic [COUNT_WIDTH-1:0] on_r, on_n, off_r, off_n;
  logic                   valid_r, valid_n;
  logic                   ovf_r, ovf_n;
  logic                   sat;

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  // Saturation is flagged on every increment that lands on or stays at all-ones,
  // so an ack during a stuck phase cannot clear overflow.
  assign cnt_inc = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;
  assign sat     = (cnt >= CNT_MAX - CNT_ONE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi_latch;
    on_n    = on_r;
    off_n   = off_r;
    valid_n = 1'b0;
    ovf_n   = ovf_r & ~bus.ack;

    if (!bus.enable) begin
      state_n = IDLE;
      cnt_n   = '0;
      ovf_n   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt_n   = '0;
          state_n = WAIT_RISE;
        end
        WAIT_RISE: begin
          if (rise) begin
            cnt_n   = CNT_ONE;
            state_n = MEAS_HIGH;
          end
        end
        MEAS_HIGH: begin
          if (fall) begin
            hi_n    = cnt;
            cnt_n   = CNT_ONE;
            state_n = MEAS_LOW;
          end else begin
            cnt_n = cnt_inc;
            if (sat) ovf_n = 1'b1;
          end
        end
        MEAS_LOW: begin
          if (rise) begin
            on_n    = hi_latch;
            off_n   = cnt;
            valid_n = 1'b1;
            cnt_n   = CNT_ONE;
            state_n = MEAS_HIGH;
          end else begin
            cnt_n = cnt_inc;
            if (sat) ovf_n = 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync     <= '0;
      s_d      <= 1'b0;
      state    <= IDLE;
      cnt      <= '0;
      hi_latch <= '0;
      on_r     <= '0;
      off_r    <= '0;
      valid_r  <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], bus.din};
      s_d      <= s;
      state    <= state_n;
      cnt      <= cnt_n;
      hi_latch <= hi_n;
      on_r     <= on_n;
      off_r    <= off_n;
      valid_r  <= valid_n;
      ovf_r    <= ovf_n;
    end
  end

  assign bus.on_ticks  = on_r;
  assign bus.off_ticks = off_r;
  assign bus.valid     = valid_r;
  assign bus.overflow  = ovf_r;
  assign bus.level     = s;

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized and directed bench for pwm_capture against a phase-length model.
module tb_pwm_capture;
  localparam int CW   = 8;
  localparam int SYNC = 2;
  localparam int MAXV = (1 << CW) - 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  pwm_capture_if #(.COUNT_WIDTH(CW)) bus ();

  pwm_capture #(.COUNT_WIDTH(CW), .SYNC_STAGES(SYNC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on   = 1'b0;
  bit rand_ack = 1'b0;
  int cyc = 0, last_v = 0, prev_v = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: phase lengths counted as plain integers, clamped when reported.
  typedef enum {M_OFF, M_ARMED, M_HI, M_LO} mphase_t;
  mphase_t     mph = M_OFF;
  bit [SYNC-1:0] mp = '0;
  bit          m_sd = 1'b0;
  int          run = 0, hi_len = 0;
  int          e_on = 0, e_off = 0;
  bit          e_valid = 1'b0, e_ovf = 1'b0;

  function automatic int clamp(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  always @(posedge clock) begin
    bit r, f, s_now;
    cyc++;
    s_now = mp[SYNC-1];
    r = s_now && !m_sd;
    f = !s_now && m_sd;
    if (reset) begin
      mph = M_OFF; mp = '0; m_sd = 1'b0; run = 0; hi_len = 0;
      e_on = 0; e_off = 0; e_valid = 1'b0; e_ovf = 1'b0;
    end else begin
      e_valid = 1'b0;
      if (bus.ack) e_ovf = 1'b0;
      if (!bus.enable) begin
        mph = M_OFF; run = 0; e_ovf = 1'b0;
      end else begin
        case (mph)
          M_OFF:   mph = M_ARMED;
          M_ARMED: if (r) begin mph = M_HI; run = 1; end
          M_HI: begin
            if (f) begin hi_len = run; run = 1; mph = M_LO; end
            else begin
              if (run < 1000000) run++;
              if (run >= MAXV) e_ovf = 1'b1;
            end
          end
          M_LO: begin
            if (r) begin
              e_on = clamp(hi_len); e_off = clamp(run); e_valid = 1'b1;
              run = 1; mph = M_HI;
            end else begin
              if (run < 1000000) run++;
              if (run >= MAXV) e_ovf = 1'b1;
            end
          end
          default: mph = M_OFF;
        endcase
      end
      m_sd = s_now;
      mp   = {mp[SYNC-2:0], bus.din};
    end
  end

  always @(negedge clock) begin
    if (chk_on) begin
      check("level", 32'(bus.level), 32'(mp[SYNC-1]));
      check("valid", 32'(bus.valid), 32'(e_valid));
      check("on_ticks", 32'(bus.on_ticks), 32'(e_on));
      check("off_ticks", 32'(bus.off_ticks), 32'(e_off));
      check("overflow", 32'(bus.overflow), 32'(e_ovf));
      if (bus.valid) begin
        prev_v = last_v;
        last_v = cyc;
      end
    end
  end

  task automatic hold(input bit lvl, input int n);
    bus.din = lvl;
    repeat (n) begin
      bus.ack = rand_ack && ($urandom_range(0, 15) == 0);
      @(negedge clock);
    end
    bus.ack = 1'b0;
  endtask

  task automatic square(input int h, input int l, input int n);
    repeat (n) begin
      hold(1'b1, h);
      hold(1'b0, l);
    end
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    @(negedge clock);
    while (!bus.valid && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (!bus.valid) check({name, "_timeout"}, 32'(bus.valid), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; bus.enable = 1'b0; bus.din = 1'b0; bus.ack = 1'b0;
    @(posedge clock);
    chk_on = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_on", 32'(bus.on_ticks), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    reset = 1'b0;

    // 10/30 square wave
    bus.enable = 1'b1;
    hold(1'b0, 5);
    square(10, 30, 4);
    hold(1'b1, 5);
    check("sq_on", 32'(bus.on_ticks), 32'd10);
    check("sq_off", 32'(bus.off_ticks), 32'd30);
    check("sq_interval", 32'(last_v - prev_v), 32'd40);

    // enable raised mid-pulse: partial high must be ignored
    bus.enable = 1'b0;
    hold(1'b0, 10);
    hold(1'b1, 3);
    bus.enable = 1'b1;
    fork
      begin hold(1'b1, 7); hold(1'b0, 30); square(10, 30, 2); hold(1'b1, 3); end
      begin
        wait_valid("mid_enable", 200);
        check("mid_on", 32'(bus.on_ticks), 32'd10);
        check("mid_off", 32'(bus.off_ticks), 32'd30);
      end
    join

    // toggling every cycle
    square(1, 1, 20);
    hold(1'b1, 5);
    check("tog_on", 32'(bus.on_ticks), 32'd1);
    check("tog_off", 32'(bus.off_ticks), 32'd1);
    check("tog_interval", 32'(last_v - prev_v), 32'd2);

    // saturation on a long low
    bus.din = 1'b0; reset = 1'b1; @(negedge clock); reset = 1'b0;
    hold(1'b0, 5);
    hold(1'b1, 5);
    hold(1'b0, 270);
    check("ovf_long_low", 32'(bus.overflow), 32'd1);
    hold(1'b0, 30);
    fork
      begin hold(1'b1, 5); hold(1'b0, 5); hold(1'b1, 8); end
      begin
        wait_valid("sat_valid", 100);
        check("sat_on", 32'(bus.on_ticks), 32'd5);
        check("sat_off", 32'(bus.off_ticks), 32'd255);
        wait_valid("post_sat_valid", 50);
        check("post_on", 32'(bus.on_ticks), 32'd5);
        check("post_off", 32'(bus.off_ticks), 32'd5);
        check("post_ovf", 32'(bus.overflow), 32'd1);
      end
    join
    bus.ack = 1'b1; @(negedge clock); bus.ack = 1'b0;
    check("ack_clear", 32'(bus.overflow), 32'd0);
    hold(1'b0, 280);
    bus.ack = 1'b1; @(negedge clock); bus.ack = 1'b0;
    check("ack_vs_sat", 32'(bus.overflow), 32'd1);

    // reset mid MEAS_HIGH, then recovery
    hold(1'b1, 6);
    bus.din = 1'b0; reset = 1'b1; @(negedge clock); reset = 1'b0;
    check("midrst_on", 32'(bus.on_ticks), 32'd0);
    check("midrst_off", 32'(bus.off_ticks), 32'd0);
    check("midrst_ovf", 32'(bus.overflow), 32'd0);
    hold(1'b0, 5);
    fork
      begin square(12, 20, 3); hold(1'b1, 3); end
      begin
        wait_valid("rst_recover", 200);
        check("rec_on", 32'(bus.on_ticks), 32'd12);
        check("rec_off", 32'(bus.off_ticks), 32'd20);
      end
    join

    // disable mid MEAS_LOW: results hold, then recovery
    hold(1'b1, 9);
    hold(1'b0, 10);
    bus.enable = 1'b0;
    hold(1'b0, 10);
    check("dis_on", 32'(bus.on_ticks), 32'd12);
    check("dis_off", 32'(bus.off_ticks), 32'd20);
    bus.enable = 1'b1;
    hold(1'b0, 5);
    fork
      begin square(7, 9, 3); hold(1'b1, 3); end
      begin
        wait_valid("dis_recover", 200);
        check("dis_rec_on", 32'(bus.on_ticks), 32'd7);
        check("dis_rec_off", 32'(bus.off_ticks), 32'd9);
      end
    join

    // randomized phases, acks and enable drops
    rand_ack = 1'b1;
    for (int k = 0; k < 120; k++) begin
      int h, l;
      h = ($urandom_range(0, 19) == 0) ? int'($urandom_range(250, 300)) : int'($urandom_range(1, 20));
      l = ($urandom_range(0, 19) == 0) ? int'($urandom_range(250, 300)) : int'($urandom_range(1, 20));
      hold(1'b1, h);
      hold(1'b0, l);
      if ($urandom_range(0, 11) == 0) begin
        bus.enable = 1'b0;
        hold(1'b0, int'($urandom_range(1, 4)));
        bus.enable = 1'b1;
      end
    end
    rand_ack = 1'b0;
    hold(1'b1, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
